// File: rtl/pmu_ahb_master.sv
// AHB-lite single-transfer master: turns word read/write commands into one
// NONSEQ transfer each and returns the result on a valid/ready response channel.
module pmu_ahb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_timeout_o,
  output logic [31:0] haddr_o,
  output logic        hwrite_o,
  output logic [1:0]  htrans_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [3:0]  hprot_o,
  output logic        hmastlock_o,
  output logic [31:0] hwdata_o,
  input  logic        hready_i,
  input  logic [1:0]  hresp_i,
  input  logic [31:0] hrdata_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [31:0]      wdata_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic [31:0]      rsp_rdata_reg;
  logic             rsp_error_reg;
  logic             rsp_timeout_reg;
  logic [31:0]      haddr_reg;
  logic             hwrite_reg;
  logic [1:0]       htrans_reg;
  logic [31:0]      hwdata_reg;

  logic hresp_err;
  logic wait_expired;

  assign hresp_err    = |hresp_i;
  // The cycle that would push the count to TIMEOUT_CYCLES abandons the phase.
  assign wait_expired = (wait_cnt_reg == CNT_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg       <= S_IDLE;
      wait_cnt_reg    <= '0;
      wdata_reg       <= '0;
      req_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_error_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      haddr_reg       <= '0;
      hwrite_reg      <= 1'b0;
      htrans_reg      <= HTRANS_IDLE;
      hwdata_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          req_ready_reg <= 1'b1;
          if (req_valid_i && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            wdata_reg     <= req_wdata_i;
            hwrite_reg    <= req_write_i;
            if (req_addr_i[1:0] != 2'b00) begin
              // Unaligned: answer immediately, bus stays idle.
              state_reg       <= S_RESP;
              rsp_valid_reg   <= 1'b1;
              rsp_error_reg   <= 1'b1;
              rsp_timeout_reg <= 1'b0;
              rsp_rdata_reg   <= '0;
            end else begin
              state_reg    <= S_ADDR;
              haddr_reg    <= req_addr_i;
              htrans_reg   <= HTRANS_NONSEQ;
              wait_cnt_reg <= '0;
            end
          end
        end

        S_ADDR: begin
          if (hready_i) begin
            state_reg    <= S_DATA;
            htrans_reg   <= HTRANS_IDLE;
            hwdata_reg   <= hwrite_reg ? wdata_reg : 32'h0;
            wait_cnt_reg <= '0;
          end else if (wait_expired) begin
            state_reg       <= S_RESP;
            htrans_reg      <= HTRANS_IDLE;
            rsp_valid_reg   <= 1'b1;
            rsp_error_reg   <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_rdata_reg   <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (hready_i) begin
            state_reg       <= S_RESP;
            hwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b1;
            rsp_error_reg   <= hresp_err;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= (!hwrite_reg && !hresp_err) ? hrdata_i : 32'h0;
          end else if (wait_expired) begin
            state_reg       <= S_RESP;
            hwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b1;
            rsp_error_reg   <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_rdata_reg   <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            state_reg       <= S_IDLE;
            req_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_error_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= '0;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_rdata_o   = rsp_rdata_reg;
  assign rsp_error_o   = rsp_error_reg;
  assign rsp_timeout_o = rsp_timeout_reg;
  assign haddr_o       = haddr_reg;
  assign hwrite_o      = hwrite_reg;
  assign htrans_o      = htrans_reg;
  assign hwdata_o      = hwdata_reg;
  assign hsize_o       = 3'b010;
  assign hburst_o      = 3'b000;
  assign hprot_o       = HPROT_VAL;
  assign hmastlock_o   = 1'b0;

endmodule
